// File: rtl/rv_decode_stage.sv
// rv_decode_stage
// Registered decode stage for the RV32I subset ADDI/ADD/SUB/NOP.
// Fetch hands over raw instruction words on a valid/ready handshake. Each word
// is decoded combinationally and registered into a two-entry buffer (output
// register plus one skid register). Backpressure from execute therefore never
// drops or duplicates an instruction.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   flush           drop everything buffered and anything accepted this cycle
//   in_valid/ready  fetch handshake; in_ready is registered (= skid empty)
//   in_instr/in_pc  raw instruction word and its PC
//   out_valid/ready execute handshake
//   out_pc .. out_illegal  decoded fields (op 0=NOP 1=ADDI 2=ADD 3=SUB 7=ILLEGAL)
//   decoded_cnt     saturating count of output handshakes
//   illegal_cnt     saturating count of output handshakes carrying an illegal op
module rv_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_ADDI    = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rdField;
  logic [4:0] rs1Field;
  logic [4:0] rs2Field;

  entry_t decoded;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic accept;
  logic drain;

  assign opcode   = in_instr[6:0];
  assign rdField  = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign rs1Field = in_instr[19:15];
  assign rs2Field = in_instr[24:20];
  assign funct7   = in_instr[31:25];

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // Decode the incoming word. Unsupported encodings collapse to an all-zero
  // entry tagged ILLEGAL so they still travel through the pipe in order.
  always_comb begin
    decoded    = '0;
    decoded.pc = in_pc;
    if (opcode == OPC_OPIMM && funct3 == 3'b000) begin
      decoded.rs1 = rs1Field;
      if (rdField == 5'd0) begin
        // ADDI to x0 is the canonical NOP: nothing to write, no immediate.
        decoded.op = OP_NOP;
      end else begin
        decoded.op  = OP_ADDI;
        decoded.rd  = rdField;
        decoded.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        decoded.we  = 1'b1;
      end
    end else if (opcode == OPC_OP && funct3 == 3'b000 &&
                 (funct7 == F7_ADD || funct7 == F7_SUB)) begin
      decoded.op  = (funct7 == F7_SUB) ? OP_SUB : OP_ADD;
      decoded.rd  = rdField;
      decoded.rs1 = rs1Field;
      decoded.rs2 = rs2Field;
      // Writes to x0 are kept as real ops but must not touch the register file.
      decoded.we  = (rdField != 5'd0);
    end else begin
      decoded.op      = OP_ILLEGAL;
      decoded.illegal = 1'b1;
    end
  end

  // Buffer next-state. in_ready_q mirrors "skid empty", so an accept can only
  // happen while the skid register is free; the skid is the overflow slot used
  // only when the output register is holding under backpressure.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = decoded;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = decoded;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // Saturating statistics, advanced only by output handshakes (flush included).
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (drain && dec_cnt_q != CNT_MAX) begin
      dec_cnt_d = dec_cnt_q + CNT_ONE;
    end
    if (drain && out_q.illegal && ill_cnt_q != CNT_MAX) begin
      ill_cnt_d = ill_cnt_q + CNT_ONE;
    end
  end

  // State registers; reset empties the buffer and holds off fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      dec_cnt_q    <= '0;
      ill_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      dec_cnt_q    <= dec_cnt_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_op      = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_we      = out_q.we;
  assign out_illegal = out_q.illegal;
  assign decoded_cnt = dec_cnt_q;
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage
// Drives two copies of rv_decode_stage (CNT_W=16 and CNT_W=2) with the same
// directed stream. Expected decoded entries are queued when fetch handshakes
// and compared against the output register whenever out_valid is high.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, out_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [2:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] decoded_cnt, illegal_cnt;

  logic        b_in_ready, b_out_valid, b_out_we, b_out_illegal;
  logic [31:0] b_out_pc, b_out_imm;
  logic [2:0]  b_out_op;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [1:0]  b_decoded_cnt, b_illegal_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } exp_t;

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;
  int   handshakes = 0;
  int   illegals = 0;
  bit   readyLive = 1'b0;

  always #5 clk = ~clk;

  rv_decode_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_we(out_we), .out_illegal(out_illegal),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  rv_decode_stage #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_op(b_out_op),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_imm(b_out_imm),
    .out_we(b_out_we), .out_illegal(b_out_illegal),
    .decoded_cnt(b_decoded_cnt), .illegal_cnt(b_illegal_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkWide(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%022h expected 0x%022h", tag, obs, exp);
    end
  endtask

  // Reference decoder written from the instruction-set encodings.
  function automatic exp_t refDecode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e = '{default: '0};
    e.pc = pc;
    if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0) begin
      e.rs1 = instr[19:15];
      if (instr[11:7] == 5'd0) begin
        e.op = 3'd0;
      end else begin
        e.op  = 3'd1;
        e.rd  = instr[11:7];
        e.imm = {{20{instr[31]}}, instr[31:20]};
        e.we  = 1'b1;
      end
    end else if (instr[6:0] == 7'h33 && instr[14:12] == 3'd0 && instr[31:25] == 7'h00) begin
      e.op = 3'd2; e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
      e.we = (instr[11:7] != 5'd0);
    end else if (instr[6:0] == 7'h33 && instr[14:12] == 3'd0 && instr[31:25] == 7'h20) begin
      e.op = 3'd3; e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
      e.we = (instr[11:7] != 5'd0);
    end else begin
      e.op = 3'd7;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // All outputs of both instances must read zero while reset is held.
  task automatic checkResetState();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_imm", out_imm, 32'd0);
    checkOutput("rst_fields", 32'({out_op, out_rd, out_rs1, out_rs2, out_we, out_illegal}), 32'd0);
    checkOutput("rst_decoded_cnt", 32'(decoded_cnt), 32'd0);
    checkOutput("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    checkOutput("rst_small_cnts", 32'({b_decoded_cnt, b_illegal_cnt, b_out_valid, b_in_ready}), 32'd0);
  endtask

  // One clock of stimulus: drive inputs, check outputs on the falling edge,
  // then update the scoreboard with what the rising edge does.
  task automatic applyStimulus(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                               input bit ordy, input bit fl);
    bit   accept;
    bit   drain;
    exp_t h;
    int   satSmall;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    satSmall = (handshakes > 3) ? 3 : handshakes;
    checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(readyLive && expQ.size() < 2));
    checkOutput("decoded_cnt", 32'(decoded_cnt), 32'(handshakes));
    checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(illegals));
    checkOutput("small_decoded_cnt", 32'(b_decoded_cnt), 32'(satSmall));
    checkOutput("small_illegal_cnt", 32'(b_illegal_cnt), 32'((illegals > 3) ? 3 : illegals));
    checkOutput("small_valid_ready", 32'({b_out_valid, b_in_ready}),
                32'({expQ.size() > 0, readyLive && expQ.size() < 2}));
    if (out_valid && expQ.size() > 0) begin
      h = expQ[0];
      checkOutput("out_pc", out_pc, h.pc);
      checkOutput("out_op", 32'(out_op), 32'(h.op));
      checkOutput("out_regs", 32'({out_rd, out_rs1, out_rs2}), 32'({h.rd, h.rs1, h.rs2}));
      checkOutput("out_imm", out_imm, h.imm);
      checkOutput("out_we_illegal", 32'({out_we, out_illegal}), 32'({h.we, h.illegal}));
      checkWide("small_entry",
                {b_out_pc, b_out_op, b_out_rd, b_out_rs1, b_out_rs2, b_out_imm, b_out_we, b_out_illegal},
                {h.pc, h.op, h.rd, h.rs1, h.rs2, h.imm, h.we, h.illegal});
    end
    drain  = out_valid && out_ready;
    accept = in_valid && in_ready;
    @(posedge clk);
    if (drain && expQ.size() > 0) begin
      handshakes++;
      if (expQ[0].illegal) illegals++;
      void'(expQ.pop_front());
    end
    if (fl) expQ.delete();
    else if (accept) expQ.push_back(refDecode(instr, pc));
    if (!rst) readyLive = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b0;

    // First edge after release raises in_ready.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Single ADDI x5,x3,7.
    applyStimulus(1'b1, 32'h00718293, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back ADD, SUB, ADDI -1.
    applyStimulus(1'b1, 32'h003100B3, 32'h0000_0004, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h40628233, 32'h0000_0008, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hFFF00093, 32'h0000_000C, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // NOP then an all-zero illegal word; ADD x0 keeps op but drops we.
    applyStimulus(1'b1, 32'h00000013, 32'h0000_0010, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 32'h0000_0014, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00310033, 32'h0000_0018, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: two accepted, third blocked until the skid drains.
    applyStimulus(1'b1, 32'h00A00513, 32'h0000_0020, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00B00593, 32'h0000_0024, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00C00613, 32'h0000_0028, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00C00613, 32'h0000_0028, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00C00613, 32'h0000_0028, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00C00613, 32'h0000_0028, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with the buffer full and a word offered.
    applyStimulus(1'b1, 32'h003100B3, 32'h0000_0040, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40628233, 32'h0000_0044, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFF00093, 32'h0000_0048, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush that coincides with an output handshake and an accepted word.
    applyStimulus(1'b1, 32'h00100093, 32'h0000_0050, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h0000_0054, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h80000093, 32'h0000_0058, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream with entries buffered.
    applyStimulus(1'b1, 32'h00718293, 32'h0000_0060, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h003100B3, 32'h0000_0064, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkResetState();
    expQ.delete();
    handshakes = 0;
    illegals   = 0;
    readyLive  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Five instructions after reset: the 2-bit counters stop at 3.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00718293, 32'h0000_0100, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 32'h0000_0104, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000007F, 32'h0000_0108, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h02310033, 32'h0000_010C, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h40628233, 32'h0000_0110, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("sat_small_decoded", 32'(b_decoded_cnt), 32'd3);
    checkOutput("wide_decoded", 32'(decoded_cnt), 32'd5);
    checkOutput("wide_illegal", 32'(illegal_cnt), 32'd3);
    checkOutput("sat_small_illegal", 32'(b_illegal_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
